// File: rtl/uart9_pkg.sv
// uart9_pkg: shared types and frame constants for the 9-bit UART path
package uart9_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} uart_rx_state_t;
    localparam int UART9_DATA_BITS  = 9;
    localparam int UART9_FRAME_BITS = 11;
    localparam int UART9_ADDR_BIT   = 8;
endpackage

// File: rtl/uart_sync2.sv
// uart_sync2: two-flop synchronizer for an asynchronous single-bit input
module uart_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);
    logic meta_q, sync_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end
    assign q_o = sync_q;
endmodule

// File: rtl/uart_rx9.sv
// uart_rx9: oversampling receiver for 11-bit frames (start, 9 data LSB-first, stop)
// presenting a 9-bit word with a one-cycle valid or frame-error strobe
module uart_rx9
    import uart9_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rx,
    output logic [UART9_DATA_BITS-1:0] dout,
    output logic                       dout_valid,
    output logic                       frame_err,
    output logic                       busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]    LAST_BIT = 4'(UART9_DATA_BITS - 1);

    uart_rx_state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0] bit_q, bit_d;
    logic [UART9_DATA_BITS-1:0] shift_q, shift_d, dout_q, dout_d;
    logic valid_q, valid_d, ferr_q, ferr_d;
    logic rx_s, tick, stop_tick;

    uart_sync2 #(.RST_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (rx),
        .q_o (rx_s)
    );

    // START waits half a bit so every later sample lands mid-bit
    assign tick      = cnt_q == (state_q == START ? HALF_END : BIT_END);
    assign stop_tick = state_q == STOP && tick;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      state_d = rx_s ? IDLE : START;
            START:     if (tick) state_d = rx_s ? IDLE : DATA;
            DATA:      if (tick && bit_q == LAST_BIT) state_d = STOP;
            STOP:      if (tick) state_d = rx_s ? IDLE : WAIT_IDLE;
            WAIT_IDLE: if (rx_s) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d   = (state_q inside {START, DATA, STOP} && !tick) ? cnt_q + CW'(1) : '0;
        bit_d   = state_q == IDLE ? 4'd0 : (state_q == DATA && tick) ? bit_q + 4'd1 : bit_q;
        shift_d = shift_q;
        if (state_q == DATA && tick) shift_d[bit_q] = rx_s;
        dout_d  = (stop_tick && rx_s) ? shift_q : dout_q;
        valid_d = stop_tick && rx_s;
        ferr_d  = stop_tick && !rx_s;
    end

    assign dout       = dout_q;
    assign dout_valid = valid_q;
    assign frame_err  = ferr_q;
    assign busy       = state_q != IDLE;
endmodule

// File: tb/tb_uart_rx9.sv
// tb_uart_rx9: directed frames with a queue scoreboard checked by per-DUT monitors
module tb_uart_rx9;
    typedef struct {
        bit         err;
        logic [8:0] d;
    } exp_t;

    logic clk = 1'b0, rst = 1'b1, rx = 1'b1, rx4 = 1'b1;
    logic [8:0] dout, dout4;
    logic dv, dv4, fe, fe4, busy, busy4;
    int checks = 0, failures = 0, cyc = 0, prev_v = -1, last_v = -1;
    exp_t q16[$], q4[$];
    exp_t e16, e4;
    logic [8:0] good16 = '0;

    uart_rx9 #(.CLKS_PER_BIT(16)) dut (
        .clk(clk), .rst(rst), .rx(rx), .dout(dout),
        .dout_valid(dv), .frame_err(fe), .busy(busy)
    );

    uart_rx9 #(.CLKS_PER_BIT(4)) dut4 (
        .clk(clk), .rst(rst), .rx(rx4), .dout(dout4),
        .dout_valid(dv4), .frame_err(fe4), .busy(busy4)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic push16(input bit err, input logic [8:0] d);
        exp_t e;
        e.err = err;
        e.d   = d;
        q16.push_back(e);
    endtask

    task automatic push4(input bit err, input logic [8:0] d);
        exp_t e;
        e.err = err;
        e.d   = d;
        q4.push_back(e);
    endtask

    // bit_ns is the transmit bit period in time units (clk period is 10)
    task automatic send(input logic [8:0] d, input bit stop, input int bit_ns, input bit four, input bit align);
        logic [10:0] f;
        f = {stop, d, 1'b0};
        if (align) begin
            @(posedge clk);
            #9;
        end
        for (int i = 0; i < 11; i++) begin
            if (four) rx4 = f[i];
            else rx = f[i];
            #(bit_ns);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (dv || fe) begin
            if (q16.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL strobe16_unexpected: got valid=%0b err=%0b dout=%0h want no strobe", dv, fe, dout);
            end else begin
                e16 = q16.pop_front();
                chk("strobe16 {err,valid,dout}", {21'd0, fe, dv, dout}, {21'd0, e16.err, !e16.err, e16.d});
            end
            if (dv) begin
                prev_v = last_v;
                last_v = cyc;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (dv4 || fe4) begin
            if (q4.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL strobe4_unexpected: got valid=%0b err=%0b dout=%0h want no strobe", dv4, fe4, dout4);
            end else begin
                e4 = q4.pop_front();
                chk("strobe4 {err,valid,dout}", {21'd0, fe4, dv4, dout4}, {21'd0, e4.err, !e4.err, e4.d});
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_dout", 32'(dout), 32'h0);
        chk("rst_valid", 32'(dv), 32'h0);
        chk("rst_ferr", 32'(fe), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_busy4", 32'(busy4), 32'h0);

        push16(1'b0, 9'h106);
        good16 = 9'h106;
        fork
            send(9'h106, 1'b1, 160, 1'b0, 1'b1);
            begin
                #800;
                chk("busy_mid_frame", 32'(busy), 32'h1);
            end
        join
        repeat (5) @(negedge clk);
        chk("busy_after_frame", 32'(busy), 32'h0);

        push16(1'b0, 9'h0F0);
        push16(1'b0, 9'h105);
        good16 = 9'h105;
        send(9'h0F0, 1'b1, 160, 1'b0, 1'b1);
        send(9'h105, 1'b1, 160, 1'b0, 1'b0);
        repeat (20) @(negedge clk);
        chk("b2b_spacing", 32'(last_v - prev_v), 32'd176);

        @(posedge clk);
        #9;
        rx = 1'b0;
        #30;
        rx = 1'b1;
        repeat (2) @(negedge clk);
        chk("glitch_busy", 32'(busy), 32'h1);
        repeat (30) @(negedge clk);
        chk("glitch_idle", 32'(busy), 32'h0);
        chk("glitch_dout", 32'(dout), 32'(good16));

        push16(1'b1, good16);
        send(9'h00E, 1'b0, 160, 1'b0, 1'b1);
        #400;
        chk("wait_idle_busy", 32'(busy), 32'h1);
        chk("ferr_dout_kept", 32'(dout), 32'(good16));
        rx = 1'b1;
        repeat (5) @(negedge clk);
        chk("wait_idle_exit", 32'(busy), 32'h0);
        push16(1'b0, 9'h0AA);
        good16 = 9'h0AA;
        send(9'h0AA, 1'b1, 160, 1'b0, 1'b1);

        fork
            send(9'h1FF, 1'b1, 160, 1'b0, 1'b1);
            begin
                #890;
                @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                chk("midrst_dout", 32'(dout), 32'h0);
                chk("midrst_valid", 32'(dv), 32'h0);
                chk("midrst_ferr", 32'(fe), 32'h0);
                chk("midrst_busy", 32'(busy), 32'h0);
            end
        join
        #200;
        push16(1'b0, 9'h1FF);
        good16 = 9'h1FF;
        send(9'h1FF, 1'b1, 160, 1'b0, 1'b1);

        push4(1'b0, 9'h106);
        send(9'h106, 1'b1, 42, 1'b1, 1'b1);
        #100;
        push4(1'b0, 9'h106);
        send(9'h106, 1'b1, 38, 1'b1, 1'b1);

        repeat (50) @(negedge clk);
        chk("q16_drained", 32'(q16.size()), 32'h0);
        chk("q4_drained", 32'(q4.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
